// File: rtl/redmule_w_loader.sv
// redmule_w_loader: sequencer in front of the RedMulE W-buffer latch array.
// Accepts W rows from the streamer, writes them into buffer rows, then walks
// the buffer in diagonal-skew order (elements fastest, then column groups).
// Each tile alternates one FILL phase and one DRAIN phase.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, n_tiles_i,     job start (accepted in IDLE only), tile count and
//   rows_i                  valid rows per tile (0 means ROWS)
//   busy_o, done_o          not-IDLE flag, one-cycle end-of-job pulse
//   in_valid_i/in_ready_o,  streamer row handshake and row payload
//   in_data_i
//   buf_write_*             buffer write port (data is a gated passthrough)
//   buf_read_en_o, buf_*_read_* buffer read port, addresses held between reads
//   row_mask_o              bit r set when r < effective rows
//   out_valid_o/out_ready_i qualifier for the buffer read data
//   stall_cnt_o             drain stall cycle count, present only when the
//                           macro REDMULE_W_LOADER_PERF_EN is defined
module redmule_w_loader #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned ELMS      = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [15:0]                      n_tiles_i,
  input  logic [$clog2(ROWS):0]            rows_i,
  output logic                             busy_o,
  output logic                             done_o,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [COLS*ELMS*WORD_SIZE-1:0]   in_data_i,
  output logic                             buf_write_en_o,
  output logic [$clog2(ROWS)-1:0]          buf_write_addr_o,
  output logic [COLS*ELMS*WORD_SIZE-1:0]   buf_wdata_o,
  output logic                             buf_read_en_o,
  output logic [$clog2(ELMS)-1:0]          buf_elms_read_addr_o,
  output logic [$clog2(COLS)-1:0]          buf_cols_read_offs_o,
  output logic [ROWS*$clog2(ROWS)-1:0]     buf_rows_read_addr_o,
  output logic [ROWS-1:0]                  row_mask_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i
`ifdef REDMULE_W_LOADER_PERF_EN
  ,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int unsigned AW  = $clog2(ROWS);
  localparam int unsigned EW  = $clog2(ELMS);
  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned RW  = $clog2(ROWS) + 1;
  localparam int unsigned NRD = COLS * ELMS;
  localparam int unsigned KW  = $clog2(NRD) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      tile_base_q, tile_base_d;
  logic [15:0]        tiles_left_q, tiles_left_d;
  logic [RW-1:0]      eff_rows_q, eff_rows_d;
  logic [RW-1:0]      fill_cnt_q, fill_cnt_d;
  logic [KW-1:0]      rd_left_q, rd_left_d;
  logic [EW-1:0]      elm_cnt_q, elm_cnt_d, elm_last_q;
  logic [CW-1:0]      col_cnt_q, col_cnt_d, col_last_q;
  logic [ROWS*AW-1:0] rows_addr_cur, rows_addr_last_q;
  logic               out_valid_q, out_valid_d;
  logic               in_hs, out_hs, read_en, tile_end;

  assign in_ready_o = (state_q == StFill);
  assign in_hs      = in_valid_i & in_ready_o;
  assign out_hs     = out_valid_q & out_ready_i;
  // A new read may issue only when the output slot is empty or being drained.
  assign read_en    = (state_q == StDrain) && (rd_left_q != '0) && (!out_valid_q || out_ready_i);
  assign tile_end   = (state_q == StDrain) && (rd_left_q == '0) && out_hs;

  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);
  assign buf_write_en_o   = in_hs;
  assign buf_write_addr_o = wr_ptr_q;
  assign buf_wdata_o      = in_hs ? in_data_i : '0;
  assign buf_read_en_o    = read_en;
  assign out_valid_o      = out_valid_q;

  // Addresses show the live read when issuing, otherwise the last issued one.
  assign buf_elms_read_addr_o = read_en ? elm_cnt_q : elm_last_q;
  assign buf_cols_read_offs_o = read_en ? col_cnt_q : col_last_q;
  assign buf_rows_read_addr_o = read_en ? rows_addr_cur : rows_addr_last_q;

  // Diagonal skew: engine row r reads buffer row (tile_base + r) mod ROWS.
  always_comb begin
    rows_addr_cur = '0;
    for (int r = 0; r < ROWS; r++) begin
      rows_addr_cur[r*AW +: AW] = AW'((int'(tile_base_q) + r) % ROWS);
    end
  end

  always_comb begin
    row_mask_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_mask_o[r] = (r < int'(eff_rows_q));
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    tile_base_d  = tile_base_q;
    tiles_left_d = tiles_left_q;
    eff_rows_d   = eff_rows_q;
    fill_cnt_d   = fill_cnt_q;
    rd_left_d    = rd_left_q;
    elm_cnt_d    = elm_cnt_q;
    col_cnt_d    = col_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (n_tiles_i != '0) begin
            state_d      = StFill;
            tiles_left_d = n_tiles_i;
            // Zero and out-of-range row counts both mean a full tile.
            eff_rows_d   = (rows_i == '0 || int'(rows_i) > ROWS) ? RW'(ROWS) : rows_i;
            tile_base_d  = wr_ptr_q;
            fill_cnt_d   = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFill: begin
        if (in_hs) begin
          wr_ptr_d   = (wr_ptr_q == AW'(ROWS - 1)) ? '0 : wr_ptr_q + AW'(1);
          fill_cnt_d = fill_cnt_q + RW'(1);
          if (fill_cnt_q + RW'(1) == eff_rows_q) begin
            state_d   = StDrain;
            rd_left_d = KW'(NRD);
            elm_cnt_d = '0;
            col_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (read_en) begin
          rd_left_d = rd_left_q - KW'(1);
          if (elm_cnt_q == EW'(ELMS - 1)) begin
            elm_cnt_d = '0;
            col_cnt_d = (col_cnt_q == CW'(COLS - 1)) ? '0 : col_cnt_q + CW'(1);
          end else begin
            elm_cnt_d = elm_cnt_q + EW'(1);
          end
        end
        if (tile_end) begin
          if (tiles_left_q > 16'd1) begin
            state_d      = StFill;
            tiles_left_d = tiles_left_q - 16'd1;
            tile_base_d  = wr_ptr_q;
            fill_cnt_d   = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (read_en) begin
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      wr_ptr_q         <= '0;
      tile_base_q      <= '0;
      tiles_left_q     <= '0;
      eff_rows_q       <= '0;
      fill_cnt_q       <= '0;
      rd_left_q        <= '0;
      elm_cnt_q        <= '0;
      col_cnt_q        <= '0;
      elm_last_q       <= '0;
      col_last_q       <= '0;
      rows_addr_last_q <= '0;
      out_valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      tile_base_q  <= tile_base_d;
      tiles_left_q <= tiles_left_d;
      eff_rows_q   <= eff_rows_d;
      fill_cnt_q   <= fill_cnt_d;
      rd_left_q    <= rd_left_d;
      elm_cnt_q    <= elm_cnt_d;
      col_cnt_q    <= col_cnt_d;
      out_valid_q  <= out_valid_d;
      if (read_en) begin
        elm_last_q       <= elm_cnt_q;
        col_last_q       <= col_cnt_q;
        rows_addr_last_q <= rows_addr_cur;
      end
    end
  end

`ifdef REDMULE_W_LOADER_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (state_q == StIdle && start_i) begin
      stall_cnt_q <= '0;
    end else if (state_q == StDrain && out_valid_q && !out_ready_i && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_redmule_w_loader.sv
// Self-checking bench for redmule_w_loader (ROWS=COLS=4, ELMS=2, WORD_SIZE=16).
// Expected buffer writes and reads are pushed to scoreboard queues when a job
// is launched and popped by a negedge monitor as the DUT produces them.
module tb_redmule_w_loader;
  localparam int W  = 16;
  localparam int DW = 4 * 2 * W;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_ready, busy, done;
  logic [15:0]   n_tiles;
  logic [2:0]    rows;
  logic [DW-1:0] in_data, wdata;
  logic          write_en, read_en, out_valid;
  logic [1:0]    write_addr, cols_offs;
  logic [0:0]    elms_addr;
  logic [7:0]    rows_addr;
  logic [3:0]    row_mask;
`ifdef REDMULE_W_LOADER_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  redmule_w_loader #(.WORD_SIZE(W), .ROWS(4), .COLS(4), .ELMS(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .n_tiles_i(n_tiles), .rows_i(rows),
    .busy_o(busy), .done_o(done), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .buf_write_en_o(write_en), .buf_write_addr_o(write_addr),
    .buf_wdata_o(wdata), .buf_read_en_o(read_en), .buf_elms_read_addr_o(elms_addr),
    .buf_cols_read_offs_o(cols_offs), .buf_rows_read_addr_o(rows_addr),
    .row_mask_o(row_mask), .out_valid_o(out_valid), .out_ready_i(out_ready)
`ifdef REDMULE_W_LOADER_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct packed {logic [1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct packed {logic [0:0] elm; logic [1:0] col; logic [7:0] rows;} rd_t;

  wr_t           exp_wr_q[$];
  rd_t           exp_rd_q[$];
  logic [DW-1:0] src_q[$];
  wr_t           w_exp, w_tmp;
  rd_t           r_exp, r_tmp;

  int errors = 0, checks = 0, cyc = 0, m_wr_ptr = 0, start_cyc = 0;
  int wr_cnt, rd_cnt, hs_cnt, done_cnt;
  int last_wr_cyc, first_rd_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
  bit src_hs = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Streamer model: presents queued rows back-to-back.
  always @(posedge clk) begin
    #1;
    if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
    in_valid = (src_q.size() > 0);
    in_data  = (src_q.size() > 0) ? src_q[0] : '0;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    src_hs = in_valid && in_ready;
    if (write_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: addr=%0d, required no write", write_addr);
      end else begin
        w_exp = exp_wr_q.pop_front();
        if (write_addr !== w_exp.addr || wdata !== w_exp.data) begin
          errors++;
          $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                   write_addr, wdata, w_exp.addr, w_exp.data);
        end
      end
    end
    if (read_en) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: elm=%0d col=%0d, required no read", elms_addr, cols_offs);
      end else begin
        r_exp = exp_rd_q.pop_front();
        if ({elms_addr, cols_offs, rows_addr} !== {r_exp.elm, r_exp.col, r_exp.rows}) begin
          errors++;
          $display("FAIL read: elm=%0d col=%0d rows=%h, required elm=%0d col=%0d rows=%h",
                   elms_addr, cols_offs, rows_addr, r_exp.elm, r_exp.col, r_exp.rows);
        end
      end
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] rows_of(input int base);
    logic [7:0] v;
    v = '0;
    for (int r = 0; r < 4; r++) v[r*2 +: 2] = 2'((base + r) % 4);
    return v;
  endfunction

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; hs_cnt = 0; done_cnt = 0;
    last_wr_cyc = -1; first_rd_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
  endtask

  // Independent model of one job: write addresses and skewed read sequence.
  task automatic push_job(input int nt, input int nr);
    int eff, base;
    eff = (nr == 0) ? 4 : nr;
    for (int t = 0; t < nt; t++) begin
      base = m_wr_ptr;
      for (int i = 0; i < eff; i++) begin
        w_tmp.data = {$urandom(), $urandom(), $urandom(), $urandom()};
        w_tmp.addr = 2'(m_wr_ptr);
        src_q.push_back(w_tmp.data);
        exp_wr_q.push_back(w_tmp);
        m_wr_ptr = (m_wr_ptr + 1) % 4;
      end
      for (int c = 0; c < 4; c++) begin
        for (int e = 0; e < 2; e++) begin
          r_tmp.elm = 1'(e); r_tmp.col = 2'(c); r_tmp.rows = rows_of(base);
          exp_rd_q.push_back(r_tmp);
        end
      end
    end
  endtask

  task automatic do_start(input int nt, input int nr);
    tick();
    start = 1'b1; n_tiles = 16'(nt); rows = 3'(nr); start_cyc = cyc;
    push_job(nt, nr);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; n_tiles = '0; rows = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready, write_en, write_addr, wdata, read_en, elms_addr, cols_offs,
         rows_addr, row_mask, out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rdy=%b we=%b re=%b mask=%b ov=%b, required 0",
               busy, done, in_ready, write_en, read_en, row_mask, out_valid);
    end
`ifdef REDMULE_W_LOADER_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d, required 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    bit ok;
    clear_stats();
    do_start(1, 4);
    @(negedge clk);
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++; $display("FAIL basic_busy_ready: got %b%b, required 11", busy, in_ready);
    end
    checks++;
    if (row_mask !== 4'b1111) begin
      errors++; $display("FAIL basic_row_mask: got %b, required 1111", row_mask);
    end
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_timeout: no done in 100 cycles"); end
    checks++;
    if (wr_cnt != 4 || rd_cnt != 8 || hs_cnt != 8) begin
      errors++;
      $display("FAIL basic_counts: wr=%0d rd=%0d hs=%0d, required 4 8 8", wr_cnt, rd_cnt, hs_cnt);
    end
    checks++;
    if (done_cyc != last_hs_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_timing: done@%0d last_hs@%0d, required done one cycle after",
               done_cyc, last_hs_cyc);
    end
    checks++;
    if (last_hs_cyc - first_hs_cyc != 7) begin
      errors++;
      $display("FAIL basic_throughput: span=%0d, required 7", last_hs_cyc - first_hs_cyc);
    end
    checks++;
    if (first_rd_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL basic_first_read: rd@%0d wr@%0d, required rd one cycle after last write",
               first_rd_cyc, last_wr_cyc);
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL basic_end: done_cnt=%0d busy=%b left_wr=%0d left_rd=%0d, required 1 0 0 0",
               done_cnt, busy, exp_wr_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_partial();
    bit ok;
    clear_stats();
    do_start(2, 3);
    @(negedge clk);
    checks++;
    if (row_mask !== 4'b0111) begin
      errors++; $display("FAIL partial_row_mask: got %b, required 0111", row_mask);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || wr_cnt != 6 || rd_cnt != 16 || done_cnt != 1 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL partial_counts: ok=%0d wr=%0d rd=%0d done=%0d, required 1 6 16 1",
               ok, wr_cnt, rd_cnt, done_cnt);
    end
  endtask

  task automatic test_stall();
    bit         ok, seen;
    int         base;
    logic [10:0] held;
    clear_stats();
    base = m_wr_ptr;
    do_start(1, 4);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_no_valid: out_valid never rose"); end
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    held = {elms_addr, cols_offs, rows_addr};
    checks++;
    if ({out_valid, read_en} !== 2'b10 || held !== {1'b1, 2'd0, rows_of(base)}) begin
      errors++;
      $display("FAIL stall_first: ov=%b re=%b addr=%h, required 1 0 %h",
               out_valid, read_en, held, {1'b1, 2'd0, rows_of(base)});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, read_en} !== 2'b10 || {elms_addr, cols_offs, rows_addr} !== held) begin
      errors++;
      $display("FAIL stall_second: ov=%b re=%b addr=%h, required 1 0 %h",
               out_valid, read_en, {elms_addr, cols_offs, rows_addr}, held);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (read_en !== 1'b1) begin
      errors++; $display("FAIL stall_resume: read_en=%b, required 1", read_en);
    end
    wait_done(100, ok);
    checks++;
    if (!ok || rd_cnt != 8 || hs_cnt != 8 || done_cyc != last_hs_cyc + 1) begin
      errors++;
      $display("FAIL stall_end: ok=%0d rd=%0d hs=%0d done@%0d hs@%0d, required 1 8 8 hs+1",
               ok, rd_cnt, hs_cnt, done_cyc, last_hs_cyc);
    end
`ifdef REDMULE_W_LOADER_PERF_EN
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++; $display("FAIL stall_cnt: got %0d, required 2", stall_cnt);
    end
`endif
  endtask

  task automatic test_zero_tiles();
    clear_stats();
    do_start(0, 4);
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL zero_state: busy=%b done=%b rdy=%b, required 1 1 0", busy, done, in_ready);
    end
    repeat (4) tick();
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1 || wr_cnt != 0 || rd_cnt != 0) begin
      errors++;
      $display("FAIL zero_end: done_cnt=%0d done@%0d start@%0d wr=%0d rd=%0d, required 1 s+1 0 0",
               done_cnt, done_cyc, start_cyc, wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_restart_in_drain();
    bit ok, seen;
    clear_stats();
    do_start(1, 4);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (read_en) begin seen = 1'b1; break; end
    end
    tick();
    start = 1'b1; n_tiles = 16'd3; rows = 3'd2;
    repeat (2) tick();
    start = 1'b0;
    wait_done(100, ok);
    repeat (4) tick();
    checks++;
    if (!seen || !ok || rd_cnt != 8 || wr_cnt != 4 || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart: seen=%0d ok=%0d rd=%0d wr=%0d done=%0d busy=%b, req 1 1 8 4 1 0",
               seen, ok, rd_cnt, wr_cnt, done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    clear_stats();
    tick();
    start = 1'b1; n_tiles = 16'd1; rows = 3'd4;
    for (int i = 0; i < 2; i++) begin
      w_tmp.data = {$urandom(), $urandom(), $urandom(), $urandom()};
      w_tmp.addr = 2'(m_wr_ptr);
      src_q.push_back(w_tmp.data);
      exp_wr_q.push_back(w_tmp);
      m_wr_ptr = (m_wr_ptr + 1) % 4;
    end
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_cnt >= 2) break;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready, write_en, write_addr, wdata, read_en, elms_addr, cols_offs,
         rows_addr, row_mask, out_valid} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b rdy=%b waddr=%0d rows=%h mask=%b, required 0",
               busy, in_ready, write_addr, rows_addr, row_mask);
    end
    m_wr_ptr = 0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    repeat (5) tick();
    checks++;
    if (done_cnt != 0 || wr_cnt != 2) begin
      errors++;
      $display("FAIL midreset_done: done_cnt=%0d wr=%0d, required 0 2", done_cnt, wr_cnt);
    end
    clear_stats();
    do_start(1, 4);
    wait_done(100, ok);
    checks++;
    if (!ok || wr_cnt != 4 || rd_cnt != 8 || done_cnt != 1 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_rerun: ok=%0d wr=%0d rd=%0d done=%0d, required 1 4 8 1",
               ok, wr_cnt, rd_cnt, done_cnt);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_partial();
    test_stall();
    test_zero_tiles();
    test_restart_in_drain();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
